// File: rtl/div_unit_e.sv
// div_unit_e: iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// Latency: start sampled at edge E0, done pulses in the cycle after E33 (33 cycles busy).
// Backpressure: busy stalls upstream stages; start is ignored unless IDLE; abort cancels.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, is_signed         begin a division (IDLE only), signed (DIV) or unsigned (DIVU)
//   dividend, divisor        rs / rt operands, sampled with start
//   abort                    execute-stage flush, returns to IDLE with no done pulse
//   busy, done, div_result   in-progress flag, one-cycle result strobe, {remainder, quotient}
module div_unit_e #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   div_result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]       state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;        // partial remainder; always < divisor magnitude after restore
    logic [WIDTH-1:0] quo;        // dividend bits shift out of the top, quotient bits in at the bottom
    logic [WIDTH-1:0] dvsr;       // divisor magnitude
    logic [WIDTH-1:0] raw_dvd;    // unmodified dividend, returned as remainder on divide-by-zero
    logic             neg_q, neg_r, dbz;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh;     // W+1-bit shifted partial remainder
    logic             trial_ok;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_fix, quo_fix;

    // Operand magnitudes; 0x80000000 negates to itself and is then treated as unsigned.
    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
        if (is_signed && dividend[WIDTH-1]) a_mag = -dividend;
        if (is_signed && divisor[WIDTH-1])  b_mag = -divisor;
    end

    // One restoring step. The difference is taken modulo 2^W: whenever the trial
    // succeeds the true difference is below the divisor, so the top bit is always zero.
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        trial_ok = (rem_sh >= {1'b0, dvsr});
        rem_sub  = rem_sh[WIDTH-1:0] - dvsr;
    end

    always_comb begin
        rem_fix = neg_r ? -rem : rem;
        quo_fix = neg_q ? -quo : quo;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_CALC;
            S_CALC: if (cnt == CW'(WIDTH - 1)) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_result <= '0;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
            raw_dvd    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dbz        <= 1'b0;
        end else begin
            state <= state_nx;
            // Registered from the next state so busy and done line up with the state register.
            busy  <= (state_nx == S_CALC) || (state_nx == S_FIX);
            done  <= (state_nx == S_DONE);
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            quo     <= a_mag;
                            dvsr    <= b_mag;
                            rem     <= '0;
                            cnt     <= '0;
                            neg_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_r   <= is_signed & dividend[WIDTH-1];
                            dbz     <= (divisor == '0);
                            raw_dvd <= dividend;
                        end
                    end
                    S_CALC: begin
                        rem <= trial_ok ? rem_sub : rem_sh[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], trial_ok};
                        cnt <= cnt + CW'(1);
                    end
                    S_FIX: begin
                        if (dbz) div_result <= {raw_dvd, {WIDTH{1'b1}}};
                        else     div_result <= {rem_fix, quo_fix};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit_e.sv
// tb_div_unit_e: scoreboard bench for div_unit_e with directed and random divisions.
// Latency: checks done arrives 34 sampling points after the start edge, busy high 33 cycles.
// Backpressure: exercises ignored starts, abort, abort+start, and mid-division reset.
module tb_div_unit_e;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [63:0] div_result;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] exp_q[$];
    logic [63:0] last_result = '0;

    div_unit_e #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    // MIPS semantics straight from integer arithmetic: truncating division,
    // remainder takes the dividend's sign; divide-by-zero yields {dividend, all-ones}.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint q, r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
        end
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_done: got result %h, want no done pulse", div_result);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (div_result !== e) begin
                    mismatched++;
                    $display("FAIL result: got %h, want %h", div_result, e);
                end
            end
        end
    end

    // Present start for the cycle ending at edge E0; returns at the first sample after E0.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input bit push);
        @(negedge clk);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        if (push) begin
            exp_q.push_back(exp);
            last_result = exp;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done (bounded) and checks latency and busy duration; returns in the DONE cycle.
    task automatic wait_done(input int already);
        int k, busy_n;
        k = already;
        busy_n = already;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
            if (busy) busy_n++;
        end
        check("latency", 64'(k), 64'd34);
        check("busy_cycles", 64'(busy_n), 64'd33);
        check("busy_low_in_done", {63'b0, busy}, 64'd0);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp);
        issue(a, b, s, exp, 1'b1);
        wait_done(1);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t dir[7] = '{
        '{32'h0000_0007, 32'h0000_0002, 1'b0, {32'h0000_0001, 32'h0000_0003}},
        '{32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}},
        '{32'h0000_0007, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}},
        '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}},
        '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0000_0000}},
        '{32'h1234_5678, 32'h0000_0000, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF}},
        '{32'h1234_5678, 32'h0000_0000, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        logic [63:0] e1;

        repeat (3) @(negedge clk);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_result", div_result, 64'd0);
        rst_n = 1'b1;

        // Directed vectors with hand-derived results.
        foreach (dir[i]) run_div(dir[i].a, dir[i].b, dir[i].s, dir[i].exp);

        // start presented in the DONE cycle is ignored.
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", {63'b0, busy}, 64'd0);

        // start re-asserted mid-division with new operands is ignored.
        e1 = {32'd4, 32'd15};
        issue(32'd199, 32'd13, 1'b0, e1, 1'b1);
        repeat (9) @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(11);

        // abort at cycle 15: busy drops, no done, result held.
        issue(32'd5000, 32'd9, 1'b0, 64'd0, 1'b0);
        repeat (14) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_result_held", div_result, last_result);
        repeat (40) @(negedge clk);
        check("abort_result_after", div_result, last_result);

        // abort and start together in IDLE: nothing starts.
        start = 1'b1; abort = 1'b1; dividend = 32'd77; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);

        // Reset pulsed at cycle 20 of a division.
        issue(32'hDEAD_BEEF, 32'd17, 1'b1, 64'd0, 1'b0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {63'b0, busy}, 64'd0);
        check("midreset_done", {63'b0, done}, 64'd0);
        check("midreset_result", div_result, 64'd0);
        last_result = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("postreset_result", div_result, 64'd0);
        run_div(32'hFFFF_FF00, 32'd16, 1'b1, ref_div(32'hFFFF_FF00, 32'd16, 1'b1));

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(1, 15));
                1: b = $urandom;
                2: b = {{16{a[31]}}, 16'($urandom)};
                default: b = (i % 8 == 0) ? 32'h0 : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            endcase
            s = 1'($urandom);
            run_div(a, b, s, ref_div(a, b, s));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
